// File: rtl/apb_master_ctrl.sv
// APB master: queues read/write commands in a small FIFO and runs them as back-to-back
// SETUP/ACCESS transfers, returning one response per command with timeout/PSLVERR status.
module apb_master_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic push, pop, fifo_nempty, xfer_ok, xfer_to, xfer_end;
    cmd_t head;

    // Readiness comes from the registered occupancy only, so a pop on a full FIFO
    // does not let a push through on the same edge.
    assign cmd_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign fifo_nempty = (count != '0);
    assign push        = cmd_valid && cmd_ready;
    assign xfer_ok     = (state == ACCESS) && pready_i;
    assign xfer_to     = (state == ACCESS) && !pready_i && (wait_cnt == WAIT_W'(TIMEOUT));
    assign xfer_end    = xfer_ok || xfer_to;
    assign pop         = fifo_nempty && ((state == IDLE) || xfer_end);
    assign head        = fifo_mem[rd_ptr];
    assign busy_o      = fifo_nempty || (state != IDLE);

    always_ff @(posedge pclk) begin
        if (push) fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= xfer_end;
            if (xfer_end) begin
                rsp_write   <= pwrite_o;
                rsp_err     <= xfer_to ? 1'b1 : pslverr_i;
                rsp_timeout <= xfer_to;
                rsp_rdata   <= (pwrite_o || xfer_to) ? '0 : prdata_i;
            end
            // Address phase fields change only when a new command is taken.
            if (pop) begin
                pwrite_o <= head.write;
                paddr_o  <= head.addr;
                pwdata_o <= head.wdata;
            end
            case (state)
                IDLE: begin
                    if (fifo_nempty) begin
                        state     <= SETUP;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (xfer_end) begin
                        penable_o <= 1'b0;
                        if (fifo_nempty) begin
                            state    <= SETUP;
                            wait_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            psel_o <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized bench for apb_master_ctrl against a transaction-queue reference model.
module tb_apb_master_ctrl;
    localparam int ADDR_W = 32, DATA_W = 8, DEPTH = 4, TMO = 16;

    logic              pclk = 1'b0;
    logic              preset_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_timeout, busy_o;
    logic [DATA_W-1:0] rsp_rdata, pwdata_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] prdata_i = '0;
    logic              pready_i = 1'b0, pslverr_i = 1'b0;

    apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy_o(busy_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } mcmd_t;

    // Reference: pending commands, command on the bus, bus phase (0 idle, 1 setup, 2 access).
    mcmd_t             q[$];
    mcmd_t             cur = '0;
    int                phase = 0, waits = 0;
    logic              e_rv = 1'b0, e_rw = 1'b0, e_re = 1'b0, e_rt = 1'b0;
    logic [DATA_W-1:0] e_rd = '0;
    int                n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int occ;
        bit push, done, err, to;
        @(posedge pclk);
        occ  = q.size();
        push = cmd_valid && (occ < DEPTH);
        done = 0; err = 0; to = 0;
        if (!preset_n) begin
            q.delete();
            phase = 0; waits = 0; cur = '0;
            e_rv = 0; e_rw = 0; e_re = 0; e_rt = 0; e_rd = '0;
        end else begin
            if (phase == 2) begin
                if (pready_i) begin done = 1; err = pslverr_i; end
                else if (waits == TMO) begin done = 1; err = 1; to = 1; end
                else waits++;
            end
            e_rv = done;
            if (done) begin
                e_rw = cur.w; e_re = err; e_rt = to;
                e_rd = (cur.w || to) ? '0 : prdata_i;
            end
            if (phase == 1) begin
                phase = 2; waits = 0;
            end else if ((phase == 0 || done) && occ > 0) begin
                cur = q.pop_front(); phase = 1;
            end else if (done) begin
                phase = 0;
            end
            if (push) q.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata});
        end
        #1;
        check("psel", 64'(psel_o), 64'(phase != 0));
        check("penable", 64'(penable_o), 64'(phase == 2));
        check("paddr", 64'(paddr_o), 64'(cur.a));
        check("pwrite", 64'(pwrite_o), 64'(cur.w));
        check("pwdata", 64'(pwdata_o), 64'(cur.d));
        check("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
        check("busy", 64'(busy_o), 64'(q.size() > 0 || phase != 0));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (e_rv || !preset_n) begin
            check("rsp_write", 64'(rsp_write), 64'(e_rw));
            check("rsp_err", 64'(rsp_err), 64'(e_re));
            check("rsp_timeout", 64'(rsp_timeout), 64'(e_rt));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        end
    endtask

    task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Hold pready low for nwait ACCESS cycles of each transfer, then raise it.
    task automatic run_waits(input int nwait, input int ncyc, input logic err, input logic [DATA_W-1:0] rd);
        repeat (ncyc) begin
            pready_i  = (phase == 2) && (waits >= nwait);
            pslverr_i = err;
            prdata_i  = rd;
            tick();
        end
    endtask

    task automatic drive_rand(input int pv, input int pr, input int pe);
        cmd_valid = ($urandom_range(99) < pv);
        cmd_write = 1'($urandom_range(1));
        cmd_addr  = $urandom;
        cmd_wdata = 8'($urandom);
        pready_i  = ($urandom_range(99) < pr);
        pslverr_i = ($urandom_range(99) < pe);
        prdata_i  = 8'($urandom);
    endtask

    initial begin
        int pr_tab[5] = '{100, 70, 30, 8, 0};
        // Reset state
        tick(); tick();
        preset_n = 1'b1;
        tick();

        // Write with zero wait states
        send(1'b1, 32'hA000, 8'hC8);
        run_waits(0, 6, 1'b0, 8'h00);

        // Read with three wait states
        send(1'b0, 32'hA001, 8'h00);
        run_waits(3, 10, 1'b0, 8'h5A);

        // Five back-to-back writes, bus stalled so the FIFO fills
        pready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b1, 32'hB000 + i, 8'(i));
        run_waits(0, 16, 1'b0, 8'h00);

        // Timeout with pready stuck low
        send(1'b0, 32'hC000, 8'h00);
        pready_i = 1'b0;
        repeat (24) tick();

        // Slave error on a read
        send(1'b0, 32'hD000, 8'h00);
        run_waits(1, 6, 1'b1, 8'h77);

        // Reset mid-ACCESS with commands queued
        pslverr_i = 1'b0;
        pready_i  = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 32'hE000 + i, 8'(8'h10 + i));
        tick(); tick();
        preset_n = 1'b0;
        tick();
        preset_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic across ready/error mixes with rare resets
        for (int seg = 0; seg < 15; seg++) begin
            int pv, pr, pe;
            pv = $urandom_range(90, 10);
            pr = pr_tab[seg % 5];
            pe = $urandom_range(30);
            repeat (250) begin
                drive_rand(pv, pr, pe);
                preset_n = ($urandom_range(399) != 0);
                tick();
            end
        end
        preset_n = 1'b1;
        cmd_valid = 1'b0;
        pready_i = 1'b1;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
